// File: rtl/shreg_uart_tx_pkg.sv
// Shared UART definitions: state encoding, byte/index widths and default bit timing.
// Intended for reuse by the matching receiver.
package shreg_uart_tx_pkg;

  localparam int unsigned UART_DATA_W           = 8;
  localparam int unsigned UART_BIT_IDX_W        = 3;
  localparam int unsigned UART_CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_RELEASE = 3'd2,
    ST_START   = 3'd3,
    ST_DATA    = 3'd4,
    ST_STOP    = 3'd5
  } uart_state_e;

  // Width of a counter spanning 0..clks_per_bit-1.
  function automatic int unsigned uart_cnt_w(input int unsigned clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while not cleared and flags the last
// cycle of every bit period with a registered one-cycle pulse.
module uart_baud_gen
  import shreg_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_bit_done
);

  localparam int unsigned      CNT_W = uart_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bit_done;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (i_clr || (r_cnt == LAST)) begin
      w_cnt_nxt = '0;
    end
  end

  // Pulse is precomputed from the next count so it is high exactly while r_cnt == LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit_done <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_bit_done <= (w_cnt_nxt == LAST);
    end
  end

  assign o_bit_done = r_bit_done;

endmodule

// File: rtl/shreg_uart_tx.sv
// 8N1 UART transmitter fed from a one-byte upstream register via a has_data/rd
// handshake; the byte is latched into a shift register and sent LSB first.
module shreg_uart_tx
  import shreg_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   has_data,
  input  logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd,
  output logic                   tx,
  output logic                   busy
);

  uart_state_e                r_state;
  logic [UART_DATA_W-1:0]     r_shift;
  logic [UART_BIT_IDX_W-1:0]  r_bit_idx;
  logic                       r_rd;
  logic                       r_tx;
  logic                       r_busy;
  logic                       w_bit_done;
  logic                       w_baud_clr;

  // Timer is held at zero outside the serial phases, so START always begins at count 0.
  assign w_baud_clr = !((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_baud_clr),
    .o_bit_done(w_bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_rd      <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (has_data) begin
            r_shift <= rd_data;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_rd    <= 1'b0;
          r_state <= ST_RELEASE;
        end
        // Wait for upstream to drop has_data so the same byte is never read twice.
        ST_RELEASE: begin
          if (!has_data) begin
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_bit_idx <= r_bit_idx + UART_BIT_IDX_W'(1);
            if (r_bit_idx == '1) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift <= {1'b0, r_shift[UART_DATA_W-1:1]};
              r_tx    <= r_shift[1];
            end
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd    <= 1'b0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd   = r_rd;
  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_shreg_uart_tx.sv
// Bench for shreg_uart_tx: per-edge expected rd/tx/busy traces computed from the
// framing rules, compared against two instances (4 and 2 clocks per bit).
module tb_shreg_uart_tx;

  localparam int MAXE = 2048;
  localparam int MAXT = 16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       has_data = 1'b0;
  logic [7:0] rd_data  = 8'h00;
  logic       rd4, tx4, busy4;
  logic       rd2, tx2, busy2;

  int n_err = 0;
  int n_chk = 0;

  // Schedule: inputs seen at edge e, and {rd,tx,busy} expected just after edge e.
  logic       sch_has  [MAXE];
  logic [7:0] sch_data [MAXE];
  logic [2:0] exp_vec  [MAXE];
  logic [2:0] obs_vec  [MAXE];
  int         sch_len;

  logic [7:0] tr_byte  [MAXT];
  logic [7:0] tr_fill  [MAXT];
  int         tr_hold  [MAXT];
  int         tr_gap   [MAXT];
  bit         tr_b2b   [MAXT];
  int         tr_base  [MAXT];
  int         tr_start [MAXT];
  int         tr_n;

  always #5 clk = ~clk;

  shreg_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .has_data(has_data), .rd_data(rd_data),
    .rd(rd4), .tx(tx4), .busy(busy4)
  );

  shreg_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .has_data(has_data), .rd_data(rd_data),
    .rd(rd2), .tx(tx2), .busy(busy2)
  );

  task automatic do_reset();
    rst = 1'b1;
    has_data = 1'b0;
    rd_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: handshake, then 10 frame bits (0, d0..d7, 1) each c cycles.
  task automatic build_sched(input int c);
    int b;
    b = 2;
    for (int e = 0; e < MAXE; e++) begin
      sch_has[e]  = 1'b0;
      sch_data[e] = 8'($urandom);
      exp_vec[e]  = 3'b010;
    end
    tr_b2b[tr_n-1] = 1'b0;
    for (int j = 0; j < tr_n; j++) begin
      int s;
      int nb;
      s = b + 2 + tr_hold[j];
      tr_base[j]  = b;
      tr_start[j] = s;
      for (int e = b; e < s; e++) begin
        sch_has[e]  = (e <= b + 1 + tr_hold[j]);
        sch_data[e] = (e == b) ? tr_byte[j] : tr_fill[j];
        exp_vec[e]  = (e == b) ? 3'b111 : 3'b011;
      end
      for (int e = s; e < s + 10 * c; e++) begin
        int   idx;
        logic bitv;
        idx = (e - s) / c;
        if (idx == 0)      bitv = 1'b0;
        else if (idx == 9) bitv = 1'b1;
        else               bitv = tr_byte[j][idx-1];
        exp_vec[e]  = {1'b0, bitv, 1'b1};
        sch_data[e] = tr_fill[j];
      end
      nb = s + 10 * c + 1 + (tr_b2b[j] ? 0 : tr_gap[j]);
      if (tr_b2b[j]) begin
        for (int e = s + 1; e < nb; e++) begin
          sch_has[e]  = 1'b1;
          sch_data[e] = tr_byte[j+1];
        end
      end
      b = nb;
    end
    sch_len = b + 1;
  endtask

  task automatic run_sched(input bit sel, input int n_edges);
    for (int e = 0; e < n_edges; e++) begin
      has_data = sch_has[e];
      rd_data  = sch_data[e];
      @(posedge clk);
      @(negedge clk);
      obs_vec[e] = sel ? {rd2, tx2, busy2} : {rd4, tx4, busy4};
    end
  endtask

  task automatic one_byte(input logic [7:0] b, input int hold, input logic [7:0] fill);
    tr_n = 1;
    tr_byte[0] = b;
    tr_hold[0] = hold;
    tr_gap[0]  = 0;
    tr_b2b[0]  = 1'b0;
    tr_fill[0] = fill;
  endtask

  task automatic test_reset();
    has_data = 1'b1;
    rd_data  = 8'hA5;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({rd4, tx4, busy4, rd2, tx2, busy2} !== 6'b010_010) begin
      n_err++;
      $display("FAIL reset_async: got %b expected 010010", {rd4, tx4, busy4, rd2, tx2, busy2});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({rd4, tx4, busy4, rd2, tx2, busy2} !== 6'b010_010) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %b expected 010010", i, {rd4, tx4, busy4, rd2, tx2, busy2});
      end
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({rd4, busy4, rd2, busy2} !== 4'b1111) begin
      n_err++;
      $display("FAIL reset_first_edge: got rd/busy x2 %b expected 1111", {rd4, busy4, rd2, busy2});
    end
    do_reset();
  endtask

  task automatic test_single_a5();
    int rd_cnt;
    int busy_fall;
    one_byte(8'hA5, 0, 8'($urandom));
    build_sched(4);
    run_sched(1'b0, sch_len);
    has_data = 1'b0;
    rd_cnt = 0;
    busy_fall = -1;
    for (int e = 0; e < sch_len; e++) begin
      n_chk++;
      if (obs_vec[e] !== exp_vec[e]) begin
        n_err++;
        $display("FAIL a5_wave edge %0d: got rd/tx/busy %b expected %b", e, obs_vec[e], exp_vec[e]);
      end
      if (obs_vec[e][2] === 1'b1) rd_cnt++;
      if (busy_fall < 0 && e > tr_start[0] && obs_vec[e][0] === 1'b0) busy_fall = e;
    end
    n_chk++;
    if (rd_cnt != 1) begin
      n_err++;
      $display("FAIL a5_rd_pulses: got %0d expected 1", rd_cnt);
    end
    n_chk++;
    if (busy_fall != tr_start[0] + 40) begin
      n_err++;
      $display("FAIL a5_busy_fall: got edge %0d expected %0d", busy_fall, tr_start[0] + 40);
    end
  endtask

  task automatic test_back_to_back();
    int next_start;
    tr_n = 2;
    tr_byte[0] = 8'h00; tr_hold[0] = 0; tr_gap[0] = 0; tr_b2b[0] = 1'b1; tr_fill[0] = 8'h00;
    tr_byte[1] = 8'hFF; tr_hold[1] = 0; tr_gap[1] = 0; tr_b2b[1] = 1'b0; tr_fill[1] = 8'($urandom);
    build_sched(4);
    run_sched(1'b0, sch_len);
    has_data = 1'b0;
    next_start = -1;
    for (int e = 0; e < sch_len; e++) begin
      n_chk++;
      if (obs_vec[e] !== exp_vec[e]) begin
        n_err++;
        $display("FAIL b2b_wave edge %0d: got rd/tx/busy %b expected %b", e, obs_vec[e], exp_vec[e]);
      end
      if (next_start < 0 && e >= tr_start[0] + 36 && obs_vec[e][1] === 1'b0) next_start = e;
    end
    n_chk++;
    if (next_start != tr_start[0] + 43) begin
      n_err++;
      $display("FAIL b2b_gap: second start at edge %0d expected %0d", next_start, tr_start[0] + 43);
    end
  endtask

  task automatic test_release_hold();
    one_byte(8'($urandom), 5, 8'($urandom));
    build_sched(4);
    run_sched(1'b0, sch_len);
    has_data = 1'b0;
    for (int e = 0; e < sch_len; e++) begin
      n_chk++;
      if (obs_vec[e] !== exp_vec[e]) begin
        n_err++;
        $display("FAIL hold_wave edge %0d: got rd/tx/busy %b expected %b", e, obs_vec[e], exp_vec[e]);
      end
    end
  endtask

  task automatic test_rd_data_change();
    one_byte(8'h42, 0, 8'h99);
    build_sched(4);
    run_sched(1'b0, sch_len);
    has_data = 1'b0;
    for (int e = 0; e < sch_len; e++) begin
      n_chk++;
      if (obs_vec[e] !== exp_vec[e]) begin
        n_err++;
        $display("FAIL data_change_wave edge %0d: got rd/tx/busy %b expected %b", e, obs_vec[e], exp_vec[e]);
      end
    end
  endtask

  task automatic test_clk2_81();
    int busy_cycles;
    one_byte(8'h81, 0, 8'($urandom));
    build_sched(2);
    run_sched(1'b1, sch_len);
    has_data = 1'b0;
    busy_cycles = 0;
    for (int e = 0; e < sch_len; e++) begin
      n_chk++;
      if (obs_vec[e] !== exp_vec[e]) begin
        n_err++;
        $display("FAIL clk2_wave edge %0d: got rd/tx/busy %b expected %b", e, obs_vec[e], exp_vec[e]);
      end
      if (e >= tr_start[0] && obs_vec[e][0] === 1'b1) busy_cycles++;
    end
    n_chk++;
    if (busy_cycles != 20) begin
      n_err++;
      $display("FAIL clk2_frame_len: got %0d cycles expected 20", busy_cycles);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    // Abort inside data bit 3 of 0x3C, then inside the start bit.
    for (int k = 0; k < 2; k++) begin
      one_byte(8'h3C, 0, 8'($urandom));
      build_sched(4);
      n = (k == 0) ? tr_start[0] + 18 : tr_start[0] + 2;
      run_sched(1'b0, n);
      for (int e = 0; e < n; e++) begin
        n_chk++;
        if (obs_vec[e] !== exp_vec[e]) begin
          n_err++;
          $display("FAIL abort%0d_prefix edge %0d: got rd/tx/busy %b expected %b", k, e, obs_vec[e], exp_vec[e]);
        end
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({rd4, tx4, busy4} !== 3'b010) begin
        n_err++;
        $display("FAIL abort%0d_async: got rd/tx/busy %b expected 010", k, {rd4, tx4, busy4});
      end
      has_data = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    one_byte(8'($urandom), 0, 8'($urandom));
    build_sched(4);
    run_sched(1'b0, sch_len);
    has_data = 1'b0;
    for (int e = 0; e < sch_len; e++) begin
      n_chk++;
      if (obs_vec[e] !== exp_vec[e]) begin
        n_err++;
        $display("FAIL post_abort_wave edge %0d: got rd/tx/busy %b expected %b", e, obs_vec[e], exp_vec[e]);
      end
    end
  endtask

  task automatic test_random();
    for (int sel = 0; sel < 2; sel++) begin
      tr_n = (sel == 0) ? 4 : 6;
      for (int j = 0; j < tr_n; j++) begin
        tr_byte[j] = 8'($urandom);
        tr_fill[j] = 8'($urandom);
        tr_hold[j] = int'($urandom_range(0, 3));
        tr_gap[j]  = int'($urandom_range(0, 2));
        tr_b2b[j]  = 1'($urandom_range(0, 1));
      end
      build_sched((sel == 0) ? 4 : 2);
      run_sched(sel[0], sch_len);
      has_data = 1'b0;
      for (int e = 0; e < sch_len; e++) begin
        n_chk++;
        if (obs_vec[e] !== exp_vec[e]) begin
          n_err++;
          $display("FAIL random%0d_wave edge %0d: got rd/tx/busy %b expected %b", sel, e, obs_vec[e], exp_vec[e]);
        end
      end
      do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_release_hold();
    test_rd_data_change();
    do_reset();
    test_clk2_81();
    do_reset();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
